jtag_shift_bridge: RTL and testbench
====================================

JTAG_SHIFT_BRIDGE -- requirements
Module: jtag_shift_bridge

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of JTAG target ports, range 1..8.
REQ-002 SHALL have parameter DIV_RST, default 8'd4: reset value of the TCK half-period divider.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous to clk and active-high.
REQ-005 SHALL have port usb_data, input, 8: command-stream byte.
REQ-006 SHALL have port usb_valid, input, 1: usb_data valid.
REQ-007 SHALL have port usb_data_ready_o, output, 1: bridge accepts a byte. Transfer = usb_valid & usb_data_ready_o.
REQ-008 SHALL have port usb_out, output, 8: response byte.
REQ-009 SHALL have port usb_out_valid, output, 1: usb_out valid.
REQ-010 SHALL have port usb_out_ready_i, input, 1: host accepts usb_out.
REQ-011 SHALL have ports tck, tms, tdi, output, NUM_CH each: per-channel JTAG drive.
REQ-012 SHALL have port tdo, input, NUM_CH: per-channel TDO, asynchronous to clk.
REQ-013 SHALL have ports trst and srst, output, 1 each: shared resets.
REQ-014 SHALL have port blink_led, output, 1: status LED.
REQ-015 SHALL have port busy_o, output, 1: high whenever state is not IDLE.

Function
REQ-016 Single-byte commands, each accepted in IDLE:
- "B"/"b": blink_led = 1/0.
- "0".."7": {tck,tms,tdi} of the selected channel = low 3 bits of the byte.
- "r","s","t","u": {trst,srst} = 00, 01, 10, 11.
- "R": respond with "1" or "0" = last captured TDO of the selected channel.
REQ-017 Two-byte commands, opcode followed by one argument byte:
- "D" + n: divider = max(n,2).
- "C" + n: channel select = n; n >= NUM_CH is ignored, select unchanged.
REQ-018 Three-byte shift command: "S" + hdr + data.
- hdr[2:0] = nbits-1 (1..8).
- hdr[3] = TMS level held for the whole shift.
- hdr[4] = capture enable.
- data = TDI bits, LSB first.
REQ-019 Unknown opcodes SHALL be consumed and ignored; state stays IDLE; no response.
REQ-020 FSM states: IDLE, ARG, HDR, DATA, SHIFT_LO, SHIFT_HI, RESP. usb_data_ready_o = 1 only in IDLE, ARG, HDR and DATA.
REQ-021 Shift timing, per bit:
- SHIFT_LO: tck = 0, tdi/tms driven, for divider+1 clks.
- SHIFT_HI: tck = 1 for divider+1 clks.
- Synchronised TDO is sampled on the last clk of SHIFT_HI into bit position i of the TDO shift register.
REQ-022 After the last bit, tck SHALL return 0 for one clk, then the FSM goes to RESP if capture is set, else IDLE. tms and tdi hold their last values.
REQ-023 Capture response SHALL be the TDO byte right-aligned: bit0 = first sampled bit; bits above nbits = 0.
REQ-024 In RESP, usb_out_valid SHALL stay high with usb_out stable until usb_out_ready_i; on transfer, usb_out_valid drops the next clk and the FSM returns to IDLE.
REQ-025 "R" SHALL also use RESP: no response is lost when usb_out_ready_i is low.
REQ-026 Unselected channels hold their tck/tms/tdi values. Changing channel mid-shift is impossible because no bytes are accepted during a shift.
REQ-027 TDO SHALL pass through a 2-flop synchroniser per channel before use.

Reset
REQ-028 When rst_i is sampled high, all outputs SHALL take these values on the next edge, including mid-shift and mid-response:
- tck, tms, tdi, trst, srst, blink_led, usb_out_valid, busy_o = 0.
- usb_out = 0.
- usb_data_ready_o = 0.
REQ-029 Reset SHALL also set: state = IDLE; divider = DIV_RST; channel select = 0; synchronisers and captured TDO = 0.
REQ-030 usb_data_ready_o SHALL go to 1 on the first clk after rst_i deasserts.

Structure
REQ-031 Package jtag_bridge_pkg SHALL hold the command-byte constants, the FSM state enum and the minimum-divider constant (2).
REQ-032 One sub-module, jtag_tdo_sync: 2-flop synchroniser of width NUM_CH.

Verification
REQ-033 Directed scenarios:
- Reset, then "S",8'h07,8'hA5 with divider 4: tck shows 8 pulses of 5 clks high / 5 clks low; tdi = 1,0,1,0,0,1,0,1; no response.
- TDO model returns 8'h3C with hdr = 8'h17: usb_out = 8'h3C exactly once.
- "C",1 then "6": channel 1 tck=1, tms=1, tdi=0; channel 0 unchanged. Then "C",5 with NUM_CH = 2: select stays 1.
- "R" with usb_out_ready_i low for 10 clks: usb_out_valid is held with a stable byte; usb_data_ready_o = 0 until the handshake completes.
- "D",0: divider clamps to 2, giving 3-clk half-periods. 3-bit shift with hdr = 8'h12 and TDO = 1: response 8'h07.
- rst_i asserted mid-SHIFT_HI: next clk all outputs at reset values; a following "B" sets blink_led.

Source files
------------

// File: rtl/jtag_bridge_pkg.sv
// Command bytes, FSM states and divider limits shared by the USB-to-JTAG shift bridge.
package jtag_bridge_pkg;

   // ASCII command bytes: B b 0 r u R D C S
   localparam logic [7:0] CMD_BLINK_ON  = 8'h42;
   localparam logic [7:0] CMD_BLINK_OFF = 8'h62;
   localparam logic [7:0] CMD_PIN_BASE  = 8'h30;
   localparam logic [7:0] CMD_RST_BASE  = 8'h72;
   localparam logic [7:0] CMD_RST_LAST  = 8'h75;
   localparam logic [7:0] CMD_READ      = 8'h52;
   localparam logic [7:0] CMD_DIV       = 8'h44;
   localparam logic [7:0] CMD_CHAN      = 8'h43;
   localparam logic [7:0] CMD_SHIFT     = 8'h53;

   localparam logic [7:0] MIN_DIV = 8'd2;

   typedef enum logic [2:0] {
      IDLE,
      ARG,
      HDR,
      DATA,
      SHIFT_LO,
      SHIFT_HI,
      RESP
   } bridge_state_e;

   function automatic logic [7:0] clamp_div(input logic [7:0] n);
      return (n < MIN_DIV) ? MIN_DIV : n;
   endfunction

endpackage

// File: rtl/jtag_tdo_sync.sv
// Two-flop synchroniser bringing the per-channel TDO lines into the clk domain.
module jtag_tdo_sync #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst_i) begin
         meta     <= '0;
         sync_out <= '0;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/jtag_shift_bridge.sv
// Byte-command bridge from a USB stream to bit-banged JTAG ports with a timed shift engine.
module jtag_shift_bridge
   import jtag_bridge_pkg::*;
#(
   parameter int         NUM_CH  = 2,
   parameter logic [7:0] DIV_RST = 8'd4
) (
   input  logic              clk,
   input  logic              rst_i,
   input  logic [7:0]        usb_data,
   input  logic              usb_valid,
   output logic              usb_data_ready_o,
   output logic [7:0]        usb_out,
   output logic              usb_out_valid,
   input  logic              usb_out_ready_i,
   output logic [NUM_CH-1:0] tck,
   output logic [NUM_CH-1:0] tms,
   output logic [NUM_CH-1:0] tdi,
   input  logic [NUM_CH-1:0] tdo,
   output logic              trst,
   output logic              srst,
   output logic              blink_led,
   output logic              busy_o
);

   localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   bridge_state_e     state;
   logic              arg_is_div;
   logic [7:0]        divider;
   logic [7:0]        cnt;
   logic [7:0]        data_sh;
   logic [7:0]        tdo_sh;
   logic [2:0]        bit_idx;
   logic [2:0]        nbits_m1;
   logic              hdr_tms;
   logic              cap_en;
   logic              tail;
   logic [SEL_W-1:0]  sel;
   logic [NUM_CH-1:0] tdo_s;
   logic [NUM_CH-1:0] tdo_cap;
   logic              xfer;

   assign xfer = usb_valid & usb_data_ready_o;

   jtag_tdo_sync #(
      .WIDTH(NUM_CH)
   ) u_tdo_sync (
      .clk     (clk),
      .rst_i   (rst_i),
      .async_in(tdo),
      .sync_out(tdo_s)
   );

   // Every output is a register; ready/busy are updated on the same edge as the state change.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         state            <= IDLE;
         usb_data_ready_o <= 1'b0;
         busy_o           <= 1'b0;
         usb_out          <= 8'd0;
         usb_out_valid    <= 1'b0;
         tck              <= '0;
         tms              <= '0;
         tdi              <= '0;
         trst             <= 1'b0;
         srst             <= 1'b0;
         blink_led        <= 1'b0;
         divider          <= DIV_RST;
         sel              <= '0;
         tdo_cap          <= '0;
         arg_is_div       <= 1'b0;
         cnt              <= 8'd0;
         data_sh          <= 8'd0;
         tdo_sh           <= 8'd0;
         bit_idx          <= 3'd0;
         nbits_m1         <= 3'd0;
         hdr_tms          <= 1'b0;
         cap_en           <= 1'b0;
         tail             <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               usb_data_ready_o <= 1'b1;
               if (xfer) begin
                  if (usb_data == CMD_BLINK_ON) begin
                     blink_led <= 1'b1;
                  end else if (usb_data == CMD_BLINK_OFF) begin
                     blink_led <= 1'b0;
                  end else if (usb_data[7:3] == CMD_PIN_BASE[7:3]) begin
                     tck[sel] <= usb_data[2];
                     tms[sel] <= usb_data[1];
                     tdi[sel] <= usb_data[0];
                  end else if (usb_data >= CMD_RST_BASE && usb_data <= CMD_RST_LAST) begin
                     {trst, srst} <= 2'(usb_data - CMD_RST_BASE);
                  end else if (usb_data == CMD_READ) begin
                     usb_out          <= {7'b0011000, tdo_cap[sel]};
                     usb_out_valid    <= 1'b1;
                     usb_data_ready_o <= 1'b0;
                     busy_o           <= 1'b1;
                     state            <= RESP;
                  end else if (usb_data == CMD_DIV || usb_data == CMD_CHAN) begin
                     arg_is_div <= (usb_data == CMD_DIV);
                     busy_o     <= 1'b1;
                     state      <= ARG;
                  end else if (usb_data == CMD_SHIFT) begin
                     busy_o <= 1'b1;
                     state  <= HDR;
                  end
               end
            end

            ARG: begin
               if (xfer) begin
                  if (arg_is_div) begin
                     divider <= clamp_div(usb_data);
                  end else if ({24'd0, usb_data} < 32'(NUM_CH)) begin
                     sel <= usb_data[SEL_W-1:0];
                  end
                  busy_o <= 1'b0;
                  state  <= IDLE;
               end
            end

            HDR: begin
               if (xfer) begin
                  nbits_m1 <= usb_data[2:0];
                  hdr_tms  <= usb_data[3];
                  cap_en   <= usb_data[4];
                  state    <= DATA;
               end
            end

            DATA: begin
               if (xfer) begin
                  data_sh          <= usb_data;
                  tdo_sh           <= 8'd0;
                  bit_idx          <= 3'd0;
                  tail             <= 1'b0;
                  tck[sel]         <= 1'b0;
                  tms[sel]         <= hdr_tms;
                  tdi[sel]         <= usb_data[0];
                  cnt              <= divider;
                  usb_data_ready_o <= 1'b0;
                  state            <= SHIFT_LO;
               end
            end

            // A one-clk SHIFT_LO visit with tail set parks tck low before leaving the shift.
            SHIFT_LO: begin
               if (tail) begin
                  tail <= 1'b0;
                  if (cap_en) begin
                     usb_out       <= tdo_sh;
                     usb_out_valid <= 1'b1;
                     state         <= RESP;
                  end else begin
                     busy_o           <= 1'b0;
                     usb_data_ready_o <= 1'b1;
                     state            <= IDLE;
                  end
               end else if (cnt == 8'd0) begin
                  tck[sel] <= 1'b1;
                  cnt      <= divider;
                  state    <= SHIFT_HI;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end

            SHIFT_HI: begin
               if (cnt == 8'd0) begin
                  tdo_sh[bit_idx] <= tdo_s[sel];
                  tdo_cap[sel]    <= tdo_s[sel];
                  tck[sel]        <= 1'b0;
                  state           <= SHIFT_LO;
                  if (bit_idx == nbits_m1) begin
                     tail <= 1'b1;
                  end else begin
                     bit_idx  <= bit_idx + 3'd1;
                     tdi[sel] <= data_sh[1];
                     data_sh  <= data_sh >> 1;
                     cnt      <= divider;
                  end
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end

            RESP: begin
               if (usb_out_ready_i) begin
                  usb_out_valid    <= 1'b0;
                  busy_o           <= 1'b0;
                  usb_data_ready_o <= 1'b1;
                  state            <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_shift_bridge.sv
// Self-checking bench for jtag_shift_bridge with a behavioural JTAG target and pulse monitor.
module tb_jtag_shift_bridge;

   localparam logic [7:0] K_S = 8'h53;
   localparam logic [7:0] K_D = 8'h44;
   localparam logic [7:0] K_C = 8'h43;
   localparam logic [7:0] K_R = 8'h52;

   logic       clk;
   logic       rst_i;
   logic [7:0] usb_data;
   logic       usb_valid;
   logic       usb_data_ready_o;
   logic [7:0] usb_out;
   logic       usb_out_valid;
   logic       usb_out_ready_i;
   logic [1:0] tck, tms, tdi, tdo;
   logic       trst, srst, blink_led, busy_o;

   int checks = 0;
   int errors = 0;

   logic [7:0] tgt_pat [2] = '{8'd0, 8'd0};
   int         fall_cnt [2] = '{0, 0};
   int         fall_base [2] = '{0, 0};
   logic       last_cap [2] = '{1'b0, 1'b0};

   logic       mon_en = 1'b0;
   int         mon_ch = 0;
   logic [1:0] tck_prev = 2'b00;
   int         rise_cnt = 0;
   int         run = 0;
   logic [7:0] tdi_bits = 8'd0;
   logic [7:0] tms_bits = 8'd0;
   int         hi_runs[$];
   int         lo_runs[$];

   logic [19:0] all_outs;
   assign all_outs = {tck, tms, tdi, trst, srst, blink_led, usb_out_valid, busy_o,
                      usb_data_ready_o, usb_out};

   jtag_shift_bridge #(
      .NUM_CH (2),
      .DIV_RST(8'd4)
   ) dut (
      .clk             (clk),
      .rst_i           (rst_i),
      .usb_data        (usb_data),
      .usb_valid       (usb_valid),
      .usb_data_ready_o(usb_data_ready_o),
      .usb_out         (usb_out),
      .usb_out_valid   (usb_out_valid),
      .usb_out_ready_i (usb_out_ready_i),
      .tck             (tck),
      .tms             (tms),
      .tdi             (tdi),
      .tdo             (tdo),
      .trst            (trst),
      .srst            (srst),
      .blink_led       (blink_led),
      .busy_o          (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Target presents pattern bit k after k falling tck edges since the shift was armed.
   for (genvar c = 0; c < 2; c++) begin : g_tgt
      int k;
      assign k = fall_cnt[c] - fall_base[c];
      assign tdo[c] = (k >= 0 && k < 8) ? tgt_pat[c][k[2:0]] : 1'b0;
   end

   always @(negedge clk) begin
      tck_prev <= tck;
      for (int c = 0; c < 2; c++) begin
         if (tck_prev[c] && !tck[c]) fall_cnt[c] <= fall_cnt[c] + 1;
      end
      if (!mon_en) begin
         rise_cnt <= 0;
         run      <= 0;
         tdi_bits <= 8'd0;
         tms_bits <= 8'd0;
         hi_runs.delete();
         lo_runs.delete();
      end else if (tck[mon_ch] == tck_prev[mon_ch]) begin
         run <= run + 1;
      end else begin
         run <= 1;
         if (tck_prev[mon_ch]) begin
            hi_runs.push_back(run);
         end else begin
            if (rise_cnt > 0) lo_runs.push_back(run);
            if (rise_cnt < 8) begin
               tdi_bits[rise_cnt] <= tdi[mon_ch];
               tms_bits[rise_cnt] <= tms[mon_ch];
            end
            rise_cnt <= rise_cnt + 1;
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: time limit reached before summary");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
         $error("[TB] check %s did not hold", tag);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      usb_data  = b;
      usb_valid = 1'b1;
      while (!usb_data_ready_o && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check_output("send_ready_timeout", 32'(n < 1000), 32'd1);
      @(posedge clk);
      #1;
      usb_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      @(negedge clk);
      while (busy_o && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check_output({tag, "_idle_timeout"}, 32'(n < 5000), 32'd1);
   endtask

   task automatic expect_resp(input logic [7:0] exp, input string tag);
      int n = 0;
      @(negedge clk);
      while (!usb_out_valid && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check_output({tag, "_resp_timeout"}, 32'(n < 5000), 32'd1);
      check_output({tag, "_resp"}, 32'(usb_out), 32'(exp));
      usb_out_ready_i = 1'b1;
      @(posedge clk);
      #1;
      usb_out_ready_i = 1'b0;
      @(negedge clk);
      check_output({tag, "_after_handshake"}, {30'd0, usb_out_valid, usb_data_ready_o}, 32'd1);
   endtask

   task automatic do_shift(input int ch, input int div_eff, input logic [7:0] hdr,
                           input logic [7:0] data, input logic [7:0] pat, input string tag);
      int         nb, other, bad_runs;
      logic       extra;
      logic [7:0] mask;
      logic [2:0] other_pins;
      nb    = int'(hdr[2:0]) + 1;
      mask  = 8'((1 << nb) - 1);
      other = 1 - ch;
      @(negedge clk);
      tgt_pat[ch]   = pat;
      fall_base[ch] = fall_cnt[ch];
      mon_ch        = ch;
      mon_en        = 1'b1;
      other_pins    = {tck[other], tms[other], tdi[other]};
      send_byte(K_S);
      send_byte(hdr);
      send_byte(data);
      if (hdr[4]) expect_resp(pat & mask, tag);
      wait_idle(tag);
      extra = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (usb_out_valid) extra = 1'b1;
      end
      check_output({tag, "_no_extra_resp"}, 32'(extra), 32'd0);
      check_output({tag, "_bits"}, {8'(rise_cnt), tdi_bits, tms_bits, 8'd0},
                   {8'(nb), data & mask, hdr[3] ? mask : 8'd0, 8'd0});
      bad_runs = 0;
      foreach (hi_runs[i]) if (hi_runs[i] != div_eff + 1) bad_runs++;
      foreach (lo_runs[i]) if (lo_runs[i] != div_eff + 1) bad_runs++;
      check_output({tag, "_run_counts"}, {16'(hi_runs.size()), 16'(lo_runs.size())},
                   {16'(nb), 16'(nb - 1)});
      check_output({tag, "_bad_runs"}, 32'(bad_runs), 32'd0);
      check_output({tag, "_pins"}, {29'd0, tck[ch], tms[ch], tdi[ch]},
                   {29'd0, 1'b0, hdr[3], data[nb-1]});
      check_output({tag, "_other_ch"}, {29'd0, tck[other], tms[other], tdi[other]},
                   {29'd0, other_pins});
      last_cap[ch] = pat[nb-1];
      mon_en = 1'b0;
   endtask

   initial begin
      int         n, ch, dv;
      logic       stable, rdy_seen;
      logic [7:0] first_byte, hdr;
      logic [2:0] ch0_pins;

      rst_i           = 1'b1;
      usb_data        = 8'd0;
      usb_valid       = 1'b0;
      usb_out_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      check_output("reset_outputs", 32'(all_outs), 32'd0);
      rst_i = 1'b0;
      @(negedge clk);
      check_output("ready_after_reset", 32'(usb_data_ready_o), 32'd1);

      do_shift(0, 4, 8'h07, 8'hA5, 8'($urandom), "shift_a5");
      do_shift(0, 4, 8'h17, 8'($urandom), 8'h3C, "shift_3c");

      ch0_pins = {tck[0], tms[0], tdi[0]};
      send_byte(K_C);
      send_byte(8'd1);
      send_byte(8'h36);
      @(negedge clk);
      check_output("pin6_ch1", {29'd0, tck[1], tms[1], tdi[1]}, 32'd6);
      check_output("pin6_ch0", {29'd0, tck[0], tms[0], tdi[0]}, {29'd0, ch0_pins});
      send_byte(K_C);
      send_byte(8'd5);
      send_byte(8'h33);
      @(negedge clk);
      check_output("sel_kept_ch1", {29'd0, tck[1], tms[1], tdi[1]}, 32'd3);
      check_output("sel_kept_ch0", {29'd0, tck[0], tms[0], tdi[0]}, {29'd0, ch0_pins});
      send_byte(K_R);
      expect_resp({7'b0011000, last_cap[1]}, "read_ch1");
      send_byte(K_C);
      send_byte(8'd0);

      send_byte(K_R);
      n = 0;
      @(negedge clk);
      while (!usb_out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_output("r_hold_timeout", 32'(n < 100), 32'd1);
      first_byte = usb_out;
      stable     = 1'b1;
      rdy_seen   = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (!usb_out_valid || usb_out !== first_byte) stable = 1'b0;
         if (usb_data_ready_o) rdy_seen = 1'b1;
      end
      check_output("r_hold_byte", 32'(first_byte), {24'd0, 7'b0011000, last_cap[0]});
      check_output("r_hold_stable", 32'(stable), 32'd1);
      check_output("r_hold_not_ready", 32'(rdy_seen), 32'd0);
      expect_resp({7'b0011000, last_cap[0]}, "r_hold");

      send_byte(K_D);
      send_byte(8'd0);
      do_shift(0, 2, 8'h12, 8'($urandom), 8'hFF, "clamp");

      for (int i = 0; i < 4; i++) begin
         dv = $urandom_range(0, 6);
         ch = $urandom_range(0, 1);
         send_byte(K_D);
         send_byte(8'(dv));
         send_byte(K_C);
         send_byte(8'(ch));
         hdr = {3'b000, 1'b1, 1'($urandom), 3'($urandom)};
         do_shift(ch, (dv < 2) ? 2 : dv, hdr, 8'($urandom), 8'($urandom), "rand_shift");
      end
      send_byte(K_C);
      send_byte(8'd0);
      send_byte(K_R);
      expect_resp({7'b0011000, last_cap[0]}, "read_ch0");

      send_byte(8'h42);
      @(negedge clk);
      check_output("blink_on", 32'(blink_led), 32'd1);
      send_byte(8'h62);
      @(negedge clk);
      check_output("blink_off", 32'(blink_led), 32'd0);
      for (int i = 0; i < 4; i++) begin
         send_byte(8'h72 + 8'(i));
         @(negedge clk);
         check_output("trst_srst", {30'd0, trst, srst}, 32'(i));
      end
      send_byte(8'h78);
      @(negedge clk);
      check_output("unknown_opcode", {29'd0, busy_o, usb_data_ready_o, usb_out_valid}, 32'd2);
      send_byte(8'h42);

      send_byte(K_D);
      send_byte(8'd20);
      send_byte(K_S);
      send_byte(8'h07);
      send_byte(8'hFF);
      n = 0;
      @(negedge clk);
      while (!tck[0] && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_output("reach_shift_hi", 32'(n < 2000), 32'd1);
      repeat (3) @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      check_output("midshift_reset_outputs", 32'(all_outs), 32'd0);
      rst_i = 1'b0;
      last_cap[0] = 1'b0;
      last_cap[1] = 1'b0;
      @(negedge clk);
      check_output("ready_after_midshift_reset", 32'(usb_data_ready_o), 32'd1);
      send_byte(8'h42);
      @(negedge clk);
      check_output("blink_after_reset", 32'(blink_led), 32'd1);
      do_shift(0, 4, 8'h10, 8'($urandom), 8'($urandom), "post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
